// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write bus of the bootloader.
// slave = the loader itself, master = the byte source / memory side.
interface inst_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );
endinterface

// File: rtl/inst_loader.sv
// Bootloader: parses SYNC/LEN/data frames, writes little-endian words to instruction memory, then releases the core.
// Defining LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte that must bring the data-byte sum to zero.
module inst_loader #(
   parameter int         IMEM_WORDS = 256,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic         clk,
   input  logic         rst_n,
   inst_loader_if.slave bus,
   output logic         cpu_run,
   output logic         busy,
   output logic         error
);

   localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
`ifdef LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE,
      ERROR
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CSUM;
`else
   localparam state_t END_STATE = DONE;
`endif

   state_t      state;
   state_t      state_next;
   logic [7:0]  len_lo;
   logic [15:0] len;
   logic [15:0] len_rx;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] shift;
   logic        fire;
   logic        is_sync;
   logic        word_done;
   logic        last_word;

   assign bus.in_ready = 1'b1;
   assign fire         = bus.in_valid;
   assign is_sync      = (bus.in_data == SYNC_BYTE);
   assign len_rx       = {bus.in_data, len_lo};
   assign word_done    = (byte_idx == 2'd3);
   assign last_word    = (word_idx == len - 16'd1);

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_check;
   assign sum_check = sum + bus.in_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Status outputs decode straight from the registered state, so they change one cycle after the deciding byte.
   always_comb begin
      state_next = state;
      cpu_run    = 1'b0;
      busy       = 1'b0;
      error      = 1'b0;
      case (state)
         IDLE: begin
            if (fire && is_sync) state_next = LEN0;
         end
         LEN0: begin
            busy = 1'b1;
            if (fire) state_next = LEN1;
         end
         LEN1: begin
            busy = 1'b1;
            if (fire) begin
               if (len_rx == 16'd0)          state_next = END_STATE;
               else if (len_rx > MAX_WORDS)  state_next = ERROR;
               else                          state_next = DATA;
            end
         end
         DATA: begin
            busy = 1'b1;
            if (fire && word_done && last_word) state_next = END_STATE;
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            busy = 1'b1;
            if (fire) state_next = (sum_check == 8'h00) ? DONE : ERROR;
         end
`endif
         DONE: begin
            cpu_run = 1'b1;
            if (fire && is_sync) state_next = LEN0;
         end
         ERROR: begin
            error = 1'b1;
            if (fire && is_sync) state_next = LEN0;
         end
         default: state_next = IDLE;
      endcase
   end

   // The 4th byte bypasses the shift register so the write is registered on the same edge that accepts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= 32'd0;
         bus.imem_wdata <= 32'd0;
         len_lo         <= 8'd0;
         len            <= 16'd0;
         word_idx       <= 16'd0;
         byte_idx       <= 2'd0;
         shift          <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
         sum            <= 8'd0;
`endif
      end else begin
         bus.imem_we <= 1'b0;
         if (fire) begin
            case (state)
               IDLE, DONE, ERROR: begin
                  if (is_sync) begin
                     word_idx <= 16'd0;
                     byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                     sum      <= 8'd0;
`endif
                  end
               end
               LEN0: len_lo <= bus.in_data;
               LEN1: begin
                  len      <= len_rx;
                  word_idx <= 16'd0;
                  byte_idx <= 2'd0;
               end
               DATA: begin
                  byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  sum      <= sum + bus.in_data;
`endif
                  case (byte_idx)
                     2'd0: shift[7:0]   <= bus.in_data;
                     2'd1: shift[15:8]  <= bus.in_data;
                     2'd2: shift[23:16] <= bus.in_data;
                     default: begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= {14'd0, word_idx, 2'b00};
                        bus.imem_wdata <= {bus.in_data, shift};
                        word_idx       <= word_idx + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: frame-level reference model plus a per-cycle write scoreboard.
// Honours LOADER_CHECKSUM_EN the same way the design does.
module tb_inst_loader;
   localparam int         IMEM_WORDS = 256;
   localparam logic [7:0] SYNC       = 8'hA5;

   logic clk = 1'b0;
   logic rst_n;
   logic cpu_run;
   logic busy;
   logic error;

   inst_loader_if bus();

   inst_loader #(.IMEM_WORDS(IMEM_WORDS), .SYNC_BYTE(SYNC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .cpu_run(cpu_run),
      .busy(busy),
      .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  frameQ[$];
   int          syncIdx;
   int          expTrig[$];
   logic [31:0] expAddr[$];
   logic [31:0] expData[$];
   logic        expRun;
   logic        expErr;

   int          sbCycle[$];
   logic [31:0] sbAddr[$];
   logic [31:0] sbData[$];
   logic [31:0] lastAddr = 32'd0;
   logic [31:0] lastData = 32'd0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Frame-level model: expected writes (with the frame byte that triggers each) and the final status.
   function automatic void modelFrame();
      int n;
      int sum;
      logic [31:0] word;
      expTrig.delete();
      expAddr.delete();
      expData.delete();
      syncIdx = -1;
      for (int i = 0; i < frameQ.size(); i++) begin
         if (frameQ[i] == SYNC) begin
            syncIdx = i;
            break;
         end
      end
      n = int'(frameQ[syncIdx + 1]) + 256 * int'(frameQ[syncIdx + 2]);
      if (n > IMEM_WORDS) begin
         expRun = 1'b0;
         expErr = 1'b1;
         return;
      end
      sum = 0;
      for (int k = 0; k < n; k++) begin
         word = 32'd0;
         for (int j = 0; j < 4; j++) begin
            word = word | (32'(frameQ[syncIdx + 3 + 4 * k + j]) << (8 * j));
            sum  = sum + int'(frameQ[syncIdx + 3 + 4 * k + j]);
         end
         expTrig.push_back(syncIdx + 3 + 4 * k + 3);
         expAddr.push_back(32'(4 * k));
         expData.push_back(word);
      end
`ifdef LOADER_CHECKSUM_EN
      expRun = ((sum + int'(frameQ[syncIdx + 3 + 4 * n])) % 256) == 0;
      expErr = !expRun;
`else
      expRun = 1'b1;
      expErr = 1'b0;
`endif
   endfunction

`ifdef LOADER_CHECKSUM_EN
   function automatic void addChecksum(input bit bad);
      int s;
      int sum;
      s = 0;
      while (frameQ[s] != SYNC) s++;
      sum = 0;
      for (int i = s + 3; i < frameQ.size(); i++) sum = sum + int'(frameQ[i]);
      frameQ.push_back(8'((256 - (sum % 256)) + (bad ? 1 : 0)));
   endfunction
`endif

   function automatic void buildRandom(input int n);
      logic [7:0] b;
      int g;
      frameQ.delete();
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
         b = 8'($urandom);
         if (b == SYNC) b = 8'h00;
         frameQ.push_back(b);
      end
      frameQ.push_back(SYNC);
      frameQ.push_back(8'(n));
      frameQ.push_back(8'(n >> 8));
      if (n <= IMEM_WORDS) begin
         for (int i = 0; i < 4 * n; i++) frameQ.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
         addChecksum($urandom_range(0, 3) == 0);
`endif
      end
   endfunction

   // Drives one byte for exactly one cycle; called and returns at 1 time unit after a rising edge.
   task automatic applyStimulus(input logic [7:0] b, output int driveCyc);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      driveCyc     = cyc;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   task automatic sendFrame(input int count, input bit randomGap);
      int t;
      int dc;
      int gap;
      t = 0;
      for (int i = 0; i < count; i++) begin
         gap = 0;
         if (randomGap && i != count - 1 && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 2);
         applyStimulus(frameQ[i], dc);
         if (t < expTrig.size() && expTrig[t] == i) begin
            sbCycle.push_back(dc + 1);
            sbAddr.push_back(expAddr[t]);
            sbData.push_back(expData[t]);
            t++;
         end
         if (i == syncIdx) begin
            checkOutput("busy_after_sync", 32'(busy), 32'd1);
            checkOutput("cpu_run_after_sync", 32'(cpu_run), 32'd0);
            checkOutput("error_after_sync", 32'(error), 32'd0);
         end
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic checkStatus();
      checkOutput("cpu_run_end", 32'(cpu_run), 32'(expRun));
      checkOutput("error_end", 32'(error), 32'(expErr));
      checkOutput("busy_end", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("pending_writes", 32'(sbCycle.size()), 32'd0);
   endtask

   // Per-cycle compare: every strobe must match the next expected write at its exact cycle; otherwise the bus holds.
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         lastAddr = 32'd0;
         lastData = 32'd0;
      end else begin
         checkOutput("in_ready", 32'(bus.in_ready), 32'd1);
         while (sbCycle.size() > 0 && sbCycle[0] < cyc) begin
            checkOutput("missed_write_cycle", 32'(cyc), 32'(sbCycle[0]));
            void'(sbCycle.pop_front());
            void'(sbAddr.pop_front());
            void'(sbData.pop_front());
         end
         if (bus.imem_we) begin
            if (sbCycle.size() == 0) begin
               checkOutput("unexpected_imem_we", 32'(bus.imem_we), 32'd0);
            end else begin
               checkOutput("write_cycle", 32'(cyc), 32'(sbCycle[0]));
               checkOutput("imem_addr", bus.imem_addr, sbAddr[0]);
               checkOutput("imem_wdata", bus.imem_wdata, sbData[0]);
               lastAddr = sbAddr[0];
               lastData = sbData[0];
               void'(sbCycle.pop_front());
               void'(sbAddr.pop_front());
               void'(sbData.pop_front());
            end
         end else begin
            checkOutput("imem_addr_hold", bus.imem_addr, lastAddr);
            checkOutput("imem_wdata_hold", bus.imem_wdata, lastData);
         end
      end
   end

   initial begin
      int dc;
      int n;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_imem_we", 32'(bus.imem_we), 32'd0);
      checkOutput("reset_imem_addr", bus.imem_addr, 32'd0);
      checkOutput("reset_imem_wdata", bus.imem_wdata, 32'd0);
      checkOutput("reset_cpu_run", 32'(cpu_run), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_error", 32'(error), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] two-word frame");
      frameQ = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      addChecksum(1'b0);
`endif
      modelFrame();
      checkOutput("model_A_writes", 32'(expTrig.size()), 32'd2);
      checkOutput("model_A_addr0", expAddr[0], 32'h0);
      checkOutput("model_A_data0", expData[0], 32'h00000013);
      checkOutput("model_A_addr1", expAddr[1], 32'h4);
      checkOutput("model_A_data1", expData[1], 32'h00100093);
      sendFrame(frameQ.size(), 1'b0);
      checkStatus();

      $display("[TB] leading garbage");
      frameQ = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
      addChecksum(1'b0);
`endif
      modelFrame();
      checkOutput("model_B_sync", 32'(syncIdx), 32'd3);
      checkOutput("model_B_data0", expData[0], 32'hDEADBEEF);
      sendFrame(frameQ.size(), 1'b1);
      checkStatus();

      $display("[TB] oversize length then recovery");
      frameQ = '{8'hA5, 8'h01, 8'h01};
      modelFrame();
      checkOutput("model_C_error", 32'(expErr), 32'd1);
      checkOutput("model_C_writes", 32'(expTrig.size()), 32'd0);
      sendFrame(frameQ.size(), 1'b0);
      checkStatus();
      buildRandom(1);
      modelFrame();
      sendFrame(frameQ.size(), 1'b1);
      checkStatus();

      $display("[TB] reset mid-frame");
      buildRandom(2);
      modelFrame();
      sendFrame(syncIdx + 9, 1'b0);
      rst_n = 1'b0;
      #2;
      checkOutput("midreset_imem_we", 32'(bus.imem_we), 32'd0);
      checkOutput("midreset_imem_addr", bus.imem_addr, 32'd0);
      checkOutput("midreset_imem_wdata", bus.imem_wdata, 32'd0);
      checkOutput("midreset_cpu_run", 32'(cpu_run), 32'd0);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_error", 32'(error), 32'd0);
      checkOutput("midreset_pending", 32'(sbCycle.size()), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(8'(i * 37 + 1), dc);
      end
      checkOutput("post_reset_busy", 32'(busy), 32'd0);
      checkOutput("post_reset_cpu_run", 32'(cpu_run), 32'd0);

      $display("[TB] resync from DONE");
      frameQ = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
      addChecksum(1'b0);
`endif
      modelFrame();
      sendFrame(frameQ.size(), 1'b0);
      checkStatus();
      buildRandom(1);
      modelFrame();
      sendFrame(frameQ.size(), 1'b0);
      checkStatus();

`ifdef LOADER_CHECKSUM_EN
      $display("[TB] checksum good and bad");
      frameQ = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
      modelFrame();
      checkOutput("model_sum_ok", 32'(expRun), 32'd1);
      checkOutput("model_sum_data", expData[0], 32'h04030201);
      sendFrame(frameQ.size(), 1'b0);
      checkStatus();
      frameQ = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
      modelFrame();
      checkOutput("model_sum_bad", 32'(expErr), 32'd1);
      sendFrame(frameQ.size(), 1'b0);
      checkStatus();
`endif

      $display("[TB] full-depth frame");
      buildRandom(IMEM_WORDS);
      modelFrame();
      checkOutput("model_last_addr", expAddr[IMEM_WORDS - 1], 32'h3FC);
      sendFrame(frameQ.size(), 1'b1);
      checkStatus();

      $display("[TB] empty frame");
      buildRandom(0);
      modelFrame();
      sendFrame(frameQ.size(), 1'b0);
      checkStatus();

      $display("[TB] random frames");
      for (int f = 0; f < 25; f++) begin
         if ($urandom_range(0, 9) == 0) n = IMEM_WORDS + 1 + $urandom_range(0, 1000);
         else                           n = $urandom_range(0, 6);
         buildRandom(n);
         modelFrame();
         sendFrame(frameQ.size(), 1'b1);
         checkStatus();
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("final_pending", 32'(sbCycle.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
